pingpong_pixel_reader: RTL



---
 rtl/pingpong_pixel_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pingpong_pixel_reader.sv
// Drains the ping-pong camera line FIFOs one line at a time and streams RGB888 pixels downstream.
// Reads are throttled so that buffered plus in-flight pixels never exceed the 2-entry output buffer.
module pingpong_pixel_reader #(
    parameter int unsigned LINE_PIXELS = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fifo_work_en,
    input  logic        i_fifo_choose,
    input  logic        i_fifo0_empty,
    input  logic        i_fifo1_empty,
    input  logic [15:0] i_fifo0_rd_data,
    input  logic [15:0] i_fifo1_rd_data,
    input  logic        i_fifo0_rd_vld,
    input  logic        i_fifo1_rd_vld,
    output logic        o_fifo0_rd_en,
    output logic        o_fifo1_rd_en,
    output logic [23:0] o_rgb,
    output logic        o_rgb_vld,
    input  logic        i_rgb_ready,
    output logic        o_line_done,
    output logic        o_overrun
);

    localparam logic [CNT_W-1:0] LINE_LOAD = CNT_W'(LINE_PIXELS);

    typedef enum logic [1:0] {IDLE, ARMED, READ, DRAIN} state_t;

    state_t           state;
    logic             sel;
    logic             choose_q;
    logic             pending;
    logic             inflight;
    logic             tail_vld;
    logic [23:0]      tail;
    logic [CNT_W-1:0] remaining;

    logic             toggle;
    logic             busy;
    logic             sel_empty;
    logic             sel_vld;
    logic [15:0]      sel_data;
    logic [23:0]      pixel;
    logic             accept;
    logic             push;
    logic [2:0]       level;
    logic             room;
    logic             rd_en;

    assign toggle    = choose_q ^ i_fifo_choose;
    assign busy      = (state == READ) || (state == DRAIN);
    assign sel_empty = sel ? i_fifo1_empty   : i_fifo0_empty;
    assign sel_vld   = sel ? i_fifo1_rd_vld  : i_fifo0_rd_vld;
    assign sel_data  = sel ? i_fifo1_rd_data : i_fifo0_rd_data;

    // RGB565 to RGB888 by replicating the top bits of each channel
    assign pixel = {sel_data[15:11], sel_data[15:13],
                    sel_data[10:5],  sel_data[10:9],
                    sel_data[4:0],   sel_data[4:2]};

    assign accept = o_rgb_vld && i_rgb_ready;
    assign push   = busy && inflight && sel_vld;

    // A read may issue only if its pixel is guaranteed a buffer slot when it returns
    assign level = 3'(o_rgb_vld) + 3'(tail_vld) + 3'(inflight);
    assign room  = level < (3'd2 + 3'(accept));
    assign rd_en = i_fifo_work_en && (state == READ) && !sel_empty
                   && (remaining != '0) && room;

    assign o_fifo0_rd_en = rd_en && !sel;
    assign o_fifo1_rd_en = rd_en && sel;
    assign o_line_done   = i_fifo_work_en && (state == DRAIN) && accept
                           && !tail_vld && !inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            choose_q  <= 1'b0;
            pending   <= 1'b0;
            inflight  <= 1'b0;
            remaining <= '0;
            tail      <= '0;
            tail_vld  <= 1'b0;
            o_rgb     <= '0;
            o_rgb_vld <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            choose_q <= i_fifo_choose;
            inflight <= rd_en;
            if (rd_en) begin
                remaining <= remaining - CNT_W'(1);
            end

            // Two-entry buffer: head is the output register, tail is the skid slot
            if (accept) begin
                if (tail_vld) begin
                    o_rgb    <= tail;
                    tail_vld <= push;
                    if (push) begin
                        tail <= pixel;
                    end
                end else if (push) begin
                    o_rgb <= pixel;
                end else begin
                    o_rgb_vld <= 1'b0;
                end
            end else if (push) begin
                if (!o_rgb_vld) begin
                    o_rgb     <= pixel;
                    o_rgb_vld <= 1'b1;
                end else begin
                    tail     <= pixel;
                    tail_vld <= 1'b1;
                end
            end

            if (!i_fifo_work_en) begin
                state     <= IDLE;
                pending   <= 1'b0;
                remaining <= '0;
                inflight  <= 1'b0;
                tail_vld  <= 1'b0;
                o_rgb_vld <= 1'b0;
                o_rgb     <= '0;
            end else begin
                if (busy && toggle) begin
                    o_overrun <= 1'b1;
                    pending   <= 1'b1;
                end
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (toggle || pending) begin
                            state     <= READ;
                            sel       <= i_fifo_choose;
                            remaining <= LINE_LOAD;
                            pending   <= 1'b0;
                        end
                    end
                    READ: begin
                        if ((remaining == '0) || (rd_en && (remaining == CNT_W'(1)))) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!inflight && !tail_vld && (!o_rgb_vld || accept)) begin
                            state <= ARMED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
